// File: rtl/pcie_sram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pcie_sram_arbiter                                            |
// | Description : Weighted two-requester arbiter in front of a single-port     |
// |               SRAM. Writes win contention for up to WR_WEIGHT consecutive  |
// |               grants, then one read is forced through. Grants are          |
// |               combinational; the SRAM command is registered one cycle      |
// |               later, and read data returns one cycle after that.           |
// |               Optional stall statistics: define PCIE_SRAM_ARB_STATS_EN.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pcie_sram_arbiter #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 10,
   parameter int WR_WEIGHT  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_gnt,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_gnt,
   output logic                  rd_rvalid,
   output logic [DATA_WIDTH-1:0] rd_rdata,
   output logic                  sram_wen,
   output logic                  sram_ren,
   output logic [ADDR_WIDTH-1:0] sram_waddr,
   output logic [ADDR_WIDTH-1:0] sram_raddr,
   output logic [DATA_WIDTH-1:0] sram_wdata,
   input  logic [DATA_WIDTH-1:0] sram_rdata,
   output logic [15:0]           stall_cnt
);

   localparam logic [3:0] RUN_MAX = WR_WEIGHT[3:0];

   // Consecutive write grants since the last read grant, saturating at RUN_MAX.
   logic [3:0] wr_run;
   logic       wr_win;

   // Writes may still win contention while the run is below the weight.
   always_comb begin
      wr_win = (wr_run < RUN_MAX);
   end

   // Grants are gated by rst_n so nothing is accepted while reset is asserted.
   assign wr_gnt = rst_n & wr_req & (~rd_req | wr_win);
   assign rd_gnt = rst_n & rd_req & (~wr_req | ~wr_win);

   // Track the write run: a read grant clears it, a write grant advances it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_run <= 4'd0;
      end else if (rd_gnt) begin
         wr_run <= 4'd0;
      end else if (wr_gnt && wr_win) begin
         wr_run <= wr_run + 4'd1;
      end
   end

   // Register the granted write into the SRAM write command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_wen   <= 1'b0;
         sram_waddr <= '0;
         sram_wdata <= '0;
      end else begin
         sram_wen <= wr_gnt;
         if (wr_gnt) begin
            sram_waddr <= wr_addr;
            sram_wdata <= wr_data;
         end
      end
   end

   // Register the granted read into the SRAM read command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_ren   <= 1'b0;
         sram_raddr <= '0;
      end else begin
         sram_ren <= rd_gnt;
         if (rd_gnt) begin
            sram_raddr <= rd_addr;
         end
      end
   end

   // Capture SRAM read data one cycle after the read command (latency 1).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_rvalid <= 1'b0;
         rd_rdata  <= '0;
      end else begin
         rd_rvalid <= sram_ren;
         if (sram_ren) begin
            rd_rdata <= sram_rdata;
         end
      end
   end

`ifdef PCIE_SRAM_ARB_STATS_EN
   logic        stall_now;
   logic [15:0] stall_q;

   assign stall_now = (wr_req & ~wr_gnt) | (rd_req & ~rd_gnt);

   // Count cycles where some requester waited, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= 16'h0000;
      end else if (stall_now && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire
